// File: rtl/vga_term_ctl.sv
// Text-mode terminal controller: turns a host character stream into bus writes to a VGA text buffer.
// Optional macro TERM_SCROLL_EN: end-of-screen scrolls rows 2..24 up instead of wrapping to row 1.
module vga_term_ctl #(
  parameter logic [15:0] VRAM_BASE = 16'h0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  ch_dat,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [15:0] m_adr_o,
  output logic [15:0] m_dat_o,
  input  logic [15:0] m_dat_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [1:0]  m_sel_o,
  input  logic        m_ack_i,
  output logic [10:0] cursor,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUT    = 3'd1;
  localparam logic [2:0] ST_SCR_RD = 3'd2;
  localparam logic [2:0] ST_SCR_WR = 3'd3;
  localparam logic [2:0] ST_CLR    = 3'd4;

  logic [2:0]  state;
  logic [6:0]  col;
  logic [10:0] row_base;
  logic [7:0]  ch_q;
  logic [9:0]  w;
  logic [9:0]  w_end;
  logic        clr_home;
  logic        bus_done;

  logic [10:0] nl_row;
  logic [2:0]  nl_state;
  logic [9:0]  nl_end;

  logic [15:0] bus_adr;
  logic [15:0] bus_dat;
  logic [1:0]  bus_sel;
  logic        bus_we;

`ifdef TERM_SCROLL_EN
  logic [15:0] rd_q;
  logic [9:0]  rd_w;
  assign rd_w = w + 10'd40;
`endif

  assign cursor   = row_base + {4'b0, col};
  assign ch_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign m_stb_o  = m_cyc_o;
  assign bus_done = m_cyc_o & m_ack_i;

  // Effect of a line feed at the current row; shared by LF and column overflow.
  always_comb begin
    nl_row   = row_base + 11'd80;
    nl_state = ST_IDLE;
    nl_end   = 10'd79;
    if (row_base >= 11'd1920) begin
`ifdef TERM_SCROLL_EN
      nl_row   = row_base;
      nl_state = ST_SCR_RD;
      nl_end   = 10'd959;
`else
      nl_row   = 11'd80;
      nl_state = ST_CLR;
      nl_end   = 10'd79;
`endif
    end
  end

  always_comb begin
    bus_adr = VRAM_BASE + {5'b0, w, 1'b0};
    bus_dat = 16'h2020;
    bus_sel = 2'b11;
    bus_we  = 1'b1;
    case (state)
      ST_PUT: begin
        bus_adr = VRAM_BASE + {5'b0, cursor};
        bus_dat = {ch_q, ch_q};
        bus_sel = cursor[0] ? 2'b10 : 2'b01;
      end
`ifdef TERM_SCROLL_EN
      ST_SCR_RD: begin
        bus_adr = VRAM_BASE + {5'b0, rd_w, 1'b0};
        bus_we  = 1'b0;
      end
      ST_SCR_WR: bus_dat = rd_q;
`endif
      default: ;
    endcase
  end

  // Bus cycle starts the cycle after state entry and drops the cycle after ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_cyc_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else if (m_cyc_o) begin
      if (m_ack_i) begin
        m_cyc_o <= 1'b0;
        m_we_o  <= 1'b0;
      end
    end else if (state != ST_IDLE) begin
      m_cyc_o <= 1'b1;
      m_adr_o <= bus_adr;
      m_dat_o <= bus_dat;
      m_sel_o <= bus_sel;
      m_we_o  <= bus_we;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      col      <= '0;
      row_base <= 11'd80;
      ch_q     <= '0;
      w        <= '0;
      w_end    <= '0;
      clr_home <= 1'b0;
`ifdef TERM_SCROLL_EN
      rd_q     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (ch_valid) begin
            ch_q <= ch_dat;
            if (ch_dat >= 8'h20) begin
              state <= ST_PUT;
            end else begin
              case (ch_dat)
                8'h0D: col <= '0;
                8'h08: if (col != 7'd0) col <= col - 7'd1;
                8'h0A: begin
                  row_base <= nl_row;
                  state    <= nl_state;
                  w        <= 10'd40;
                  w_end    <= nl_end;
                  clr_home <= 1'b0;
                end
                8'h0C: begin
                  state    <= ST_CLR;
                  w        <= 10'd40;
                  w_end    <= 10'd999;
                  clr_home <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_PUT: begin
          if (bus_done) begin
            if (col == 7'd79) begin
              col      <= '0;
              row_base <= nl_row;
              state    <= nl_state;
              w        <= 10'd40;
              w_end    <= nl_end;
              clr_home <= 1'b0;
            end else begin
              col   <= col + 7'd1;
              state <= ST_IDLE;
            end
          end
        end
`ifdef TERM_SCROLL_EN
        ST_SCR_RD: begin
          if (bus_done) begin
            rd_q  <= m_dat_i;
            state <= ST_SCR_WR;
          end
        end
        ST_SCR_WR: begin
          if (bus_done) begin
            w <= w + 10'd1;
            if (w == 10'd959) begin
              w_end <= 10'd999;
              state <= ST_CLR;
            end else begin
              state <= ST_SCR_RD;
            end
          end
        end
`endif
        ST_CLR: begin
          if (bus_done) begin
            if (w == w_end) begin
              state <= ST_IDLE;
              if (clr_home) begin
                col      <= '0;
                row_base <= 11'd80;
              end
            end else begin
              w <= w + 10'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_term_ctl.sv
// Directed bench for vga_term_ctl with a byte-addressed text-buffer slave model.
module tb_vga_term_ctl;

  localparam logic [15:0] BASE = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ch_dat = '0;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic [15:0] m_adr_o, m_dat_o;
  logic [15:0] rd_dat = '0;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [1:0]  m_sel_o;
  logic        ack_slv = 1'b0;
  logic        ack_stray = 1'b0;
  wire         m_ack = ack_slv | ack_stray;
  logic [10:0] cursor;
  logic        busy;

  vga_term_ctl #(.VRAM_BASE(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .ch_dat(ch_dat), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(rd_dat),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_ack_i(m_ack), .cursor(cursor), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:2047];
  int          waits = 0;
  int          preload_cmd = 0;
  int          wcnt = 0;
  int          idx, word;
  int          writes = 0, low_writes = 0, breaks = 0, bad_bus = 0, reads = 0;
  int          prev_word = -10;
  logic [15:0] last_adr = '0, last_dat = '0;
  logic [1:0]  last_sel = '0;

  // Slave: acks after `waits` negedges of a live cycle; logs writes into the byte array.
  always @(negedge clk) begin
    if (preload_cmd == 1) for (int i = 0; i < 2048; i++) mem[i] = 8'(i / 80);
    else if (preload_cmd == 2) for (int i = 0; i < 2048; i++) mem[i] = 8'hFF;
    if (rst || !m_cyc_o) begin
      ack_slv = 1'b0; wcnt = 0;
    end else if (ack_slv) begin
      ack_slv = 1'b0; wcnt = 0;
    end else if (wcnt < waits) begin
      wcnt++;
    end else begin
      ack_slv = 1'b1; wcnt = 0;
      idx = int'(m_adr_o - BASE);
      word = idx / 2;
      if (!m_stb_o || idx >= 2000) bad_bus++;
      else if (m_we_o) begin
        writes++;
        if (word < 40) low_writes++;
        if (word != prev_word + 1) breaks++;
        prev_word = word;
        if (m_sel_o[0]) mem[word*2]   = m_dat_o[7:0];
        if (m_sel_o[1]) mem[word*2+1] = m_dat_o[15:8];
        last_adr = m_adr_o; last_dat = m_dat_o; last_sel = m_sel_o;
      end else begin
        rd_dat = {mem[word*2+1], mem[word*2]};
        reads++;
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin @(negedge clk); n++; end
    check({"idle_", tag}, {31'd0, busy}, 32'd0);
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    while (!ch_ready && n < 20000) begin @(negedge clk); n++; end
    ch_dat = c; ch_valid = 1'b1;
    @(posedge clk); #1 ch_valid = 1'b0;
  endtask

  task automatic do_preload(input int cmd);
    @(posedge clk); preload_cmd = cmd;
    @(posedge clk); preload_cmd = 0;
  endtask

  int w0, lo0, br0, ready_low, bad, n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'd0, m_cyc_o}, 0);
    check("rst_stb", {31'd0, m_stb_o}, 0);
    check("rst_we", {31'd0, m_we_o}, 0);
    check("rst_sel", {30'd0, m_sel_o}, 0);
    check("rst_adr", {16'd0, m_adr_o}, 0);
    check("rst_dat", {16'd0, m_dat_o}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_cursor", {21'd0, cursor}, 80);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, ch_ready}, 1);

    // 'A' at offset 80
    w0 = writes;
    send(8'h41);
    ready_low = 0;
    @(negedge clk);
    while (!ch_ready && ready_low < 100) begin ready_low++; @(negedge clk); end
    check("a_ready_low", ready_low, 2);
    check("a_writes", writes - w0, 1);
    check("a_adr", {16'd0, last_adr}, 32'h0850);
    check("a_sel", {30'd0, last_sel}, 32'h1);
    check("a_dat", {16'd0, last_dat}, 32'h4141);
    check("a_cursor", {21'd0, cursor}, 81);

    // 'B' at odd offset 81, then CR
    send(8'h42); wait_idle("b");
    check("b_adr", {16'd0, last_adr}, 32'h0851);
    check("b_sel", {30'd0, last_sel}, 32'h2);
    check("b_dat", {16'd0, last_dat}, 32'h4242);
    check("b_cursor", {21'd0, cursor}, 82);
    w0 = writes;
    send(8'h0D);
    @(negedge clk);
    check("cr_cursor", {21'd0, cursor}, 80);
    check("cr_ready", {31'd0, ch_ready}, 1);
    check("cr_nowrite", writes - w0, 0);

    // BS at col 0, ignored control code, BS at col 1, LF
    send(8'h08); @(negedge clk);
    check("bs0_cursor", {21'd0, cursor}, 80);
    send(8'h41); send(8'h41); wait_idle("aa");
    w0 = writes;
    send(8'h01); @(negedge clk);
    check("ctl_cursor", {21'd0, cursor}, 82);
    send(8'h08); @(negedge clk);
    check("bs_cursor", {21'd0, cursor}, 81);
    send(8'h0A); @(negedge clk);
    check("lf_cursor", {21'd0, cursor}, 161);
    check("ctl_nowrite", writes - w0, 0);

    // ack outside a bus cycle: idle, then the cycle between accept and strobe
    w0 = writes;
    @(negedge clk); ack_stray = 1'b1; @(negedge clk); ack_stray = 1'b0;
    check("stray_idle_busy", {31'd0, busy}, 0);
    send(8'h43);
    ack_stray = 1'b1;
    @(posedge clk); #1 ack_stray = 1'b0;
    wait_idle("stray");
    check("stray_writes", writes - w0, 1);
    check("stray_adr", {16'd0, last_adr}, 32'h08A1);
    check("stray_cursor", {21'd0, cursor}, 162);

    // FF with two wait states
    do_preload(2);
    waits = 2;
    w0 = writes; lo0 = low_writes; br0 = breaks;
    send(8'h0C); wait_idle("ff");
    check("ff_writes", writes - w0, 960);
    check("ff_low", low_writes - lo0, 0);
    check("ff_seq_breaks", breaks - br0, 1);
    check("ff_cursor", {21'd0, cursor}, 80);
    bad = 0;
    for (int i = 0; i < 80; i++) if (mem[i] !== 8'hFF) bad++;
    for (int i = 80; i < 2000; i++) if (mem[i] !== 8'h20) bad++;
    check("ff_mem", bad, 0);
    waits = 0;

    // 80 characters wrap to the next row
    for (int i = 0; i < 80; i++) send(8'h61);
    wait_idle("wrap");
    check("wrap_cursor", {21'd0, cursor}, 160);
    check("wrap_last_adr", {16'd0, last_adr}, 32'h089F);

    // Row 24 col 5, then LF at end of screen
    send(8'h0C); wait_idle("ff2");
    for (int i = 0; i < 23; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    wait_idle("pos");
    check("pos_cursor", {21'd0, cursor}, 1925);
    do_preload(1);
    w0 = writes; lo0 = low_writes;
    send(8'h0A); wait_idle("eos");
    check("eos_low", low_writes - lo0, 0);
    bad = 0;
    for (int i = 0; i < 80; i++) if (mem[i] !== 8'h00) bad++;
`ifdef TERM_SCROLL_EN
    check("eos_writes", writes - w0, 960);
    check("eos_cursor", {21'd0, cursor}, 1925);
    for (int k = 1; k < 24; k++)
      for (int c = 0; c < 80; c++) if (mem[k*80+c] !== 8'(k + 1)) bad++;
    for (int c = 0; c < 80; c++) if (mem[1920+c] !== 8'h20) bad++;
`else
    check("eos_writes", writes - w0, 40);
    check("eos_cursor", {21'd0, cursor}, 85);
    for (int c = 0; c < 80; c++) if (mem[80+c] !== 8'h20) bad++;
    for (int k = 2; k < 25; k++)
      for (int c = 0; c < 80; c++) if (mem[k*80+c] !== 8'(k)) bad++;
`endif
    check("eos_mem", bad, 0);

    // Reset while a multi-word operation has its strobe up
    waits = 2;
`ifdef TERM_SCROLL_EN
    send(8'h0A);
`else
    send(8'h0C);
`endif
    n = 0;
    repeat (12) @(negedge clk);
    while (!m_stb_o && n < 100) begin @(negedge clk); n++; end
    check("abort_stb_seen", {31'd0, m_stb_o}, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_cyc", {31'd0, m_cyc_o}, 0);
    check("abort_stb", {31'd0, m_stb_o}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_cursor", {21'd0, cursor}, 80);
    @(negedge clk); rst = 1'b0;
    waits = 0;
    repeat (5) @(negedge clk);
    check("abort_stays_idle", {31'd0, busy}, 0);
    w0 = writes;
    send(8'h5A); wait_idle("z");
    check("z_writes", writes - w0, 1);
    check("z_adr", {16'd0, last_adr}, 32'h0850);
    check("z_sel", {30'd0, last_sel}, 32'h1);
    check("z_dat", {16'd0, last_dat}, 32'h5A5A);
    check("bad_bus", bad_bus, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_term_ctl.md
VGA_TERM_CTL -- requirements
Module: vga_term_ctl

Interface
REQ-001 Parameter VRAM_BASE, default 16'h0000, byte base address of the text video buffer on the bus (2048-byte aligned).
REQ-002 wb_clk_i  in  1  clock; all logic is rising-edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 ch_dat  in  8  character/control code from the host stream.
REQ-005 ch_valid  in  1  ch_dat valid.
REQ-006 ch_ready  out  1  controller accepts ch_dat this cycle.
REQ-007 m_adr_o  out  16  bus byte address; m_dat_o out 16 write data; m_dat_i in 16 read data.
REQ-008 m_cyc_o, m_stb_o, m_we_o  out  1 each  bus cycle, strobe, write enable; m_sel_o out 2 byte select; m_ack_i in 1 slave acknowledge.
REQ-009 cursor  out  11  cursor byte offset in the buffer (row*80+col), feeds the video adapter cursor input.
REQ-010 busy  out  1  high whenever state is not IDLE.

Function
REQ-011 Screen is 80x25 bytes; row 0 (offsets 0-79) is the service line and SHALL never be written by this block; text area is rows 1-24 (offsets 80-1999).
REQ-012 Internal col (0-79) and row_base (80..1920, step 80); cursor = row_base + col at all times.
REQ-013 States: IDLE, PUT, SCR_RD, SCR_WR, CLR; ch_ready = 1 only in IDLE; a code is taken when ch_valid & ch_ready.
REQ-014 Bus: one cycle outstanding; m_cyc_o = m_stb_o, asserted from the cycle after state entry and held with stable address/data/sel until m_ack_i; deasserted the cycle after ack.
REQ-015 Code >= 8'h20 -> PUT: address VRAM_BASE+cursor, m_we_o=1, m_dat_o={ch,ch}, m_sel_o = cursor[0] ? 2'b10 : 2'b01; on ack col+1 and return to IDLE.
REQ-016 col overflow (col 79 after PUT) -> col=0 then newline per REQ-018.
REQ-017 8'h0D CR: col=0, no bus cycle, stays IDLE (ch_ready high next cycle). 8'h08 BS: col-1 if col>0 else unchanged, no bus cycle.
REQ-018 8'h0A LF: row_base+80 if row_base<1920, no bus cycle; at row_base=1920 enter end-of-screen handling (Configuration), col unchanged.
REQ-019 8'h0C FF: CLR over words 40..999 (byte offsets 80-1999), cursor=80 after last ack.
REQ-020 Other codes 00-1F: discarded, accepted in one cycle, no effect.
REQ-021 CLR writes m_dat_o=16'h2020, m_sel_o=2'b11, one word per bus cycle, ascending address.
REQ-022 Scroll: for w=40..959, SCR_RD reads word w+40 (m_we_o=0, sel 2'b11), latch m_dat_i at ack, SCR_WR writes it to word w; then CLR words 960..999; cursor row_base stays 1920.
REQ-023 Word address on bus = VRAM_BASE + 2*w; word counter 10 bits, terminal compare exact (no wrap past 999).
REQ-024 m_ack_i outside an active cycle SHALL be ignored.

Reset
REQ-025 On wb_rst_i: state IDLE, col=0, row_base=80 (cursor=80), m_cyc_o=m_stb_o=m_we_o=0, m_sel_o=0, m_adr_o=0, m_dat_o=0, busy=0; ch_ready=1 after release.
REQ-026 Reset mid-operation aborts immediately: bus strobes drop asynchronously, partial scroll/clear is not resumed.

Configuration
REQ-027 Macro TERM_SCROLL_EN: defined -> end-of-screen performs scroll per REQ-022.
REQ-028 Undefined -> end-of-screen sets row_base=80 and CLRs row 1 only (words 40..79); SCR_RD/SCR_WR logic absent.

Verification
REQ-029 Reset, then ch 8'h41 -> one write at VRAM_BASE+80, sel 2'b01, dat 16'h4141; cursor 81; ch_ready low exactly from accept to cycle after ack.
REQ-030 Send 8'h42 at cursor 81 -> address +81 (word 40), sel 2'b10; then 8'h0D -> cursor 80 with no bus cycle.
REQ-031 8'h0C with slave acking after 2 wait states -> 960 writes of 16'h2020, words 40..999, none to words 0..39; cursor 80.
REQ-032 TERM_SCROLL_EN: preload row r with byte r, cursor at row 24 col 5, send 8'h0A -> row k holds k+1 for k=1..23, row 24 all 8'h20, row 0 untouched, cursor 1925.
REQ-033 Without TERM_SCROLL_EN: same stimulus -> only words 40..79 written with 16'h2020, cursor 85.
REQ-034 Assert wb_rst_i during scroll with m_stb_o high -> m_cyc_o/m_stb_o low same cycle, cursor 80, busy 0, next char written at offset 80.
